// File: rtl/keccak_round_sequencer.sv
// keccak_round_sequencer
//   Round sequencer for the low-throughput Keccak-f[1600] core. A request is
//   accepted, the permutation then runs NR rounds (one per cycle), and the
//   result is offered downstream with a valid/ready handshake. A new request
//   may be accepted in the same cycle the result is consumed (no bubble).
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   request a permutation of the absorbed block
//   in_ready   a request can be accepted this cycle
//   load_en    state register loads the absorbed block (request accepted)
//   round      one-hot round index, bit k during round k, zero when idle/done
//   round_num  binary round number, zero when not running
//   round_en   state register takes the round function output this cycle
//   last       final round in progress
//   out_valid  permuted state is valid
//   out_ready  downstream consumes the permuted state
//   abort      synchronous abort, returns to IDLE; wins over everything else

module keccak_round_sequencer #(
    parameter int NR = 24,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          load_en,
    output logic [NR-1:0] round,
    output logic [CW-1:0] round_num,
    output logic          round_en,
    output logic          last,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          abort
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [NR-1:0] round_nxt;
    logic [CW-1:0] round_num_nxt;
    logic          accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            round     <= '0;
            round_num <= '0;
        end else begin
            state     <= state_nxt;
            round     <= round_nxt;
            round_num <= round_num_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        round_nxt     = round;
        round_num_nxt = round_num;

        in_ready  = !abort && ((state == IDLE) || ((state == DONE) && out_ready));
        accept    = in_valid && in_ready;
        load_en   = accept;
        round_en  = (state == RUN);
        last      = (state == RUN) && round[NR-1];
        out_valid = (state == DONE);

        if (abort) begin
            state_nxt     = IDLE;
            round_nxt     = '0;
            round_num_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state_nxt     = RUN;
                        round_nxt     = NR'(1);
                        round_num_nxt = '0;
                    end
                end
                RUN: begin
                    if (round[NR-1]) begin
                        state_nxt     = DONE;
                        round_nxt     = '0;
                        round_num_nxt = '0;
                    end else begin
                        round_nxt     = {round[NR-2:0], 1'b0};
                        round_num_nxt = round_num + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        // accept implies out_ready here, so a queued request
                        // restarts immediately without passing through IDLE
                        if (accept) begin
                            state_nxt     = RUN;
                            round_nxt     = NR'(1);
                            round_num_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt     = IDLE;
                    round_nxt     = '0;
                    round_num_nxt = '0;
                end
            endcase
        end
    end

endmodule
